mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
EX/MEM data-memory access stage, directly downstream of the ID/EX pipeline register. It consumes the registered address, read/write select, data-enable and IP-write flags, and runs a req/ack handshake with the data memory. It stalls upstream until the access completes, then presents a one-cycle write-back result with the IP-write flag.

Parameters:
ADDR_W, 20, memory address width (matches ID/EX address field)
DATA_W, 32, data bus width
TIMEOUT, 255, max REQ cycles without ack before abort (1..2^CNT_W-1)
CNT_W, 8, timeout counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
ex_address  in  ADDR_W  access address from ID/EX
ex_datarw  in  1  1 = write, 0 = read
ex_dataena  in  1  memory operation present this cycle
ex_ip_write  in  1  IP-write flag from ID/EX
ex_wdata  in  DATA_W  store data
stall  out  1  hold ID/EX and earlier stages (combinational)
mem_req  out  1  memory request (registered)
mem_rw  out  1  latched ex_datarw
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched store data
mem_ack  in  1  memory completion, single-cycle pulse
mem_rdata  in  DATA_W  read data, valid with mem_ack
wb_valid  out  1  one-cycle pulse: result available
wb_data  out  DATA_W  read data (0 for writes and aborts)
wb_ip_write  out  1  registered IP-write flag for write-back
err_timeout  out  1  one-cycle pulse on abort

Behaviour:
- Reset (async): state=IDLE, mem_req=0, mem_rw=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_data=0, wb_ip_write=0, err_timeout=0, counter=0. Reset during REQ drops mem_req immediately. No write-back is produced for the aborted access.
- FSM states: IDLE, REQ. Two-bit encoding, with unused codes returning to IDLE.
- IDLE, ex_dataena=1: latch address, rw and wdata into mem_*. Latch ex_ip_write. Next state is REQ, with mem_req=1 from the next cycle. Counter is cleared.
- IDLE, ex_dataena=0: pass-through. wb_ip_write<=ex_ip_write, wb_valid<=ex_ip_write, wb_data<=0. This gives 1-cycle latency.
- REQ: mem_req=1. mem_addr, mem_rw and mem_wdata are held stable. Counter increments each cycle without ack.
- REQ with mem_ack=1: go to IDLE and drop mem_req at the next edge. Next cycle: wb_valid=1, wb_data = mem_rdata for a read or 0 for a write, wb_ip_write = latched flag.
- REQ with no ack and counter==TIMEOUT-1: go to IDLE and drop mem_req. Next cycle: err_timeout=1, wb_valid=1, wb_data=0, wb_ip_write=0.
- An ack arriving in the same cycle as the timeout wins; err_timeout is not asserted.
- stall = (IDLE & ex_dataena) | (REQ & ~mem_ack & ~timeout_hit). Stall falls in the completion cycle, so upstream advances at that edge and the next operation is sampled in IDLE the following cycle. Back-to-back accesses therefore cost 2 cycles minimum each.
- mem_ack in IDLE is ignored. wb_valid and err_timeout are high for exactly one cycle.
- Best-case read latency: ex_dataena seen in cycle 0, mem_req in cycle 1, ack in cycle 1, wb_valid in cycle 2.

Decomposition:
- Shared package holds the state encoding (ST_IDLE=2'd0, ST_REQ=2'd1), RW_READ/RW_WRITE constants, and the default ADDR_W/DATA_W.
- One sub-module, mem_timeout_cnt: CNT_W counter with clear and enable inputs and an output hit = (count==TIMEOUT-1).
- FSM and datapath latches stay in the top module.

Test Plan:
- Reset: assert rst mid-REQ -> mem_req=0 and all outputs 0 asynchronously. After release, state is IDLE and no wb_valid pulse occurs.
- Read: ex_dataena=1, ex_datarw=0, addr=20'h0ABCD, ack in first REQ cycle with rdata=32'hDEADBEEF -> mem_req high for 1 cycle, stall high for 1 cycle, wb_valid and wb_data=DEADBEEF at cycle 2.
- Write with wait states: datarw=1, wdata=32'h12345678, ack after 5 REQ cycles -> mem_addr/mem_wdata stable for all 5 cycles, stall high for 5 cycles, wb_data=0 on wb_valid.
- Timeout: no ack, TIMEOUT=4 -> mem_req high for 4 cycles, then err_timeout and wb_valid pulse for 1 cycle with wb_data=0. A second run with ack on the 4th cycle -> no err_timeout.
- Back-to-back: two reads presented consecutively with immediate acks -> two wb_valid pulses 2 cycles apart, and each access is accepted exactly once.
- Pass-through: ex_dataena=0, ex_ip_write=1 -> wb_valid=1 and wb_ip_write=1 the next cycle, with stall=0 and mem_req=0 throughout.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the EX/MEM data-memory access stage.
// State encoding, read/write select values and default bus widths.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter for an outstanding memory request.
// hit flags the last cycle allowed before the request is aborted.
module mem_timeout_cnt
    import mem_access_stage_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [CNT_W-1:0] count;

    // Count cycles spent waiting; clear has priority over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Terminal count decode.
    always_comb begin
        hit = (count == CNT_W'(TIMEOUT - 1));
    end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM data-memory access stage with req/ack handshake and timeout.
// Stalls upstream while an access is outstanding, then pulses write-back.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ex_address,
    input  logic              ex_datarw,
    input  logic              ex_dataena,
    input  logic              ex_ip_write,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_ip_write,
    output logic              err_timeout
);

    state_t state;
    state_t next_state;

    logic in_idle;
    logic in_req;
    logic accept;
    logic done;
    logic cnt_hit;
    logic timeout_hit;
    logic ip_lat;

    mem_timeout_cnt #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (~in_req),
        .en  (in_req & ~mem_ack),
        .hit (cnt_hit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: accept in IDLE, leave REQ on ack or timeout.
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE: begin
                next_state = ex_dataena ? ST_REQ : ST_IDLE;
            end
            ST_REQ: begin
                next_state = (mem_ack | cnt_hit) ? ST_IDLE : ST_REQ;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // FSM-derived controls; stall drops in the completion cycle.
    always_comb begin
        in_idle     = (state == ST_IDLE);
        in_req      = (state == ST_REQ);
        accept      = in_idle & ex_dataena;
        done        = in_req & mem_ack;
        timeout_hit = in_req & ~mem_ack & cnt_hit;
        stall       = accept | (in_req & ~mem_ack & ~cnt_hit);
    end

    // Registered request line follows the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req <= 1'b0;
        end else begin
            mem_req <= (next_state == ST_REQ);
        end
    end

    // Capture the access on acceptance; held stable while in REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_rw    <= RW_READ;
            mem_wdata <= '0;
            ip_lat    <= 1'b0;
        end else if (accept) begin
            mem_addr  <= ex_address;
            mem_rw    <= ex_datarw;
            mem_wdata <= ex_wdata;
            ip_lat    <= ex_ip_write;
        end
    end

    // One-cycle write-back: pass-through, completion or abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_ip_write <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_ip_write <= 1'b0;
            err_timeout <= 1'b0;
            if (in_idle & ~ex_dataena) begin
                wb_valid    <= ex_ip_write;
                wb_ip_write <= ex_ip_write;
            end else if (done) begin
                wb_valid    <= 1'b1;
                wb_ip_write <= ip_lat;
                if (mem_rw == RW_READ) begin
                    wb_data <= mem_rdata;
                end
            end else if (timeout_hit) begin
                wb_valid    <= 1'b1;
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
// Two instances: long timeout for handshakes, TIMEOUT=4 for aborts.
module tb_mem_access_stage;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [AW-1:0] ex_address;
    logic          ex_datarw;
    logic          ex_dataena;
    logic          ex_ip_write;
    logic [DW-1:0] ex_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    logic          stall;
    logic          mem_req;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          wb_valid;
    logic [DW-1:0] wb_data;
    logic          wb_ip_write;
    logic          err_timeout;

    logic          t_stall;
    logic          t_mem_req;
    logic          t_mem_rw;
    logic [AW-1:0] t_mem_addr;
    logic [DW-1:0] t_mem_wdata;
    logic          t_wb_valid;
    logic [DW-1:0] t_wb_data;
    logic          t_wb_ip_write;
    logic          t_err_timeout;

    int checks;
    int failures;

    mem_access_stage #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(16),
        .CNT_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_address (ex_address),
        .ex_datarw  (ex_datarw),
        .ex_dataena (ex_dataena),
        .ex_ip_write(ex_ip_write),
        .ex_wdata   (ex_wdata),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_ip_write(wb_ip_write),
        .err_timeout(err_timeout)
    );

    mem_access_stage #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(4),
        .CNT_W  (8)
    ) dut4 (
        .clk        (clk),
        .rst        (rst),
        .ex_address (ex_address),
        .ex_datarw  (ex_datarw),
        .ex_dataena (ex_dataena),
        .ex_ip_write(ex_ip_write),
        .ex_wdata   (ex_wdata),
        .stall      (t_stall),
        .mem_req    (t_mem_req),
        .mem_rw     (t_mem_rw),
        .mem_addr   (t_mem_addr),
        .mem_wdata  (t_mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wb_valid   (t_wb_valid),
        .wb_data    (t_wb_data),
        .wb_ip_write(t_wb_ip_write),
        .err_timeout(t_err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_dataena  = 1'b0;
        ex_datarw   = 1'b0;
        ex_ip_write = 1'b0;
        ex_address  = '0;
        ex_wdata    = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", mem_req, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_err", err_timeout, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_stall", stall, 0);
        rst = 1'b0;

        // Read with immediate ack
        ex_dataena  = 1'b1;
        ex_datarw   = 1'b0;
        ex_address  = 20'h0ABCD;
        ex_ip_write = 1'b1;
        #1;
        check("rd_c0_stall", stall, 1);
        check("rd_c0_req", mem_req, 0);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        #1;
        check("rd_c1_req", mem_req, 1);
        check("rd_c1_addr", mem_addr, 20'h0ABCD);
        check("rd_c1_rw", mem_rw, 0);
        check("rd_c1_stall", stall, 0);
        check("rd_c1_wbv", wb_valid, 0);
        tick();
        idle_inputs();
        #1;
        check("rd_c2_wbv", wb_valid, 1);
        check("rd_c2_data", wb_data, 32'hDEADBEEF);
        check("rd_c2_ip", wb_ip_write, 1);
        check("rd_c2_req", mem_req, 0);
        check("rd_c2_stall", stall, 0);
        tick();
        check("rd_c3_wbv", wb_valid, 0);

        // Write with wait states, ack in the 5th REQ cycle
        ex_dataena = 1'b1;
        ex_datarw  = 1'b1;
        ex_address = 20'h12345;
        ex_wdata   = 32'h12345678;
        #1;
        check("wr_c0_stall", stall, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            mem_ack   = (i == 4);
            mem_rdata = 32'hAAAAAAAA;
            #1;
            check("wr_req", mem_req, 1);
            check("wr_addr", mem_addr, 20'h12345);
            check("wr_wdata", mem_wdata, 32'h12345678);
            check("wr_rw", mem_rw, 1);
            check("wr_stall", stall, (i < 4) ? 1 : 0);
        end
        tick();
        idle_inputs();
        #1;
        check("wr_wbv", wb_valid, 1);
        check("wr_data", wb_data, 0);
        check("wr_ip", wb_ip_write, 0);
        check("wr_err", err_timeout, 0);
        tick();
        check("wr_wbv_off", wb_valid, 0);

        // Pass-through of IP write
        ex_ip_write = 1'b1;
        #1;
        check("pt_stall0", stall, 0);
        check("pt_req0", mem_req, 0);
        tick();
        ex_ip_write = 1'b0;
        #1;
        check("pt_wbv", wb_valid, 1);
        check("pt_ip", wb_ip_write, 1);
        check("pt_data", wb_data, 0);
        check("pt_stall1", stall, 0);
        check("pt_req1", mem_req, 0);
        tick();
        check("pt_wbv_off", wb_valid, 0);

        // Back-to-back reads
        ex_dataena = 1'b1;
        ex_datarw  = 1'b0;
        ex_address = 20'h00100;
        #1;
        check("bb_c0_stall", stall, 1);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h11111111;
        #1;
        check("bb_c1_addr", mem_addr, 20'h00100);
        check("bb_c1_stall", stall, 0);
        tick();
        ex_address = 20'h00200;
        mem_ack    = 1'b0;
        #1;
        check("bb_c2_wbv", wb_valid, 1);
        check("bb_c2_data", wb_data, 32'h11111111);
        check("bb_c2_req", mem_req, 0);
        check("bb_c2_stall", stall, 1);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h22222222;
        #1;
        check("bb_c3_req", mem_req, 1);
        check("bb_c3_addr", mem_addr, 20'h00200);
        check("bb_c3_wbv", wb_valid, 0);
        tick();
        idle_inputs();
        #1;
        check("bb_c4_wbv", wb_valid, 1);
        check("bb_c4_data", wb_data, 32'h22222222);
        tick();
        check("bb_c5_wbv", wb_valid, 0);
        check("bb_c5_req", mem_req, 0);

        // Clean restart for the timeout instance
        rst = 1'b1;
        #2;
        rst = 1'b0;

        // Timeout, no ack
        ex_dataena  = 1'b1;
        ex_datarw   = 1'b0;
        ex_address  = 20'h00055;
        ex_ip_write = 1'b1;
        #1;
        check("to_c0_stall", t_stall, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_req", t_mem_req, 1);
            check("to_stall", t_stall, (i < 3) ? 1 : 0);
            check("to_err_early", t_err_timeout, 0);
        end
        tick();
        idle_inputs();
        #1;
        check("to_err", t_err_timeout, 1);
        check("to_wbv", t_wb_valid, 1);
        check("to_data", t_wb_data, 0);
        check("to_ip", t_wb_ip_write, 0);
        check("to_req_off", t_mem_req, 0);
        tick();
        check("to_err_off", t_err_timeout, 0);
        check("to_wbv_off", t_wb_valid, 0);

        // Ack on the last allowed cycle wins over timeout
        ex_dataena  = 1'b1;
        ex_address  = 20'h00066;
        ex_ip_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_ack   = (i == 3);
            mem_rdata = 32'h0BADF00D;
            #1;
            check("ta_req", t_mem_req, 1);
            check("ta_stall", t_stall, (i < 3) ? 1 : 0);
        end
        tick();
        idle_inputs();
        #1;
        check("ta_err", t_err_timeout, 0);
        check("ta_wbv", t_wb_valid, 1);
        check("ta_data", t_wb_data, 32'h0BADF00D);
        check("ta_ip", t_wb_ip_write, 1);

        // Asynchronous reset in the middle of REQ
        tick();
        ex_dataena  = 1'b1;
        ex_address  = 20'h3C3C3;
        ex_ip_write = 1'b1;
        tick();
        idle_inputs();
        #1;
        check("ar_req_before", mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_req", mem_req, 0);
        check("ar_addr", mem_addr, 0);
        check("ar_wbv", wb_valid, 0);
        check("ar_stall", stall, 0);
        check("ar_t_req", t_mem_req, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_post_wbv", wb_valid, 0);
            check("ar_post_req", mem_req, 0);
            check("ar_post_err", err_timeout, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
